// File: rtl/multi_word_fifo.sv
// Circular FIFO that stores WR_N words per accepted push and releases RD_N words per accepted pop.
// Handshake flags come from the registered count only; the storage array itself is never reset.
module multi_word_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int WR_N  = 4,
    parameter int RD_N  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DW*WR_N-1:0]       wr_data,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic [DW*RD_N-1:0]       rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     wr_ovf,
    output logic                     rd_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] WR_LIMIT = CW'(DEPTH - WR_N);
    localparam logic [CW-1:0] WR_STEP  = CW'(WR_N);
    localparam logic [CW-1:0] RD_STEP  = CW'(RD_N);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] WPTR_INC = AW'(WR_N);
    localparam logic [AW-1:0] RPTR_INC = AW'(RD_N);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count_next;
    logic          push_acc;
    logic          pop_acc;

    assign wr_ready = (count <= WR_LIMIT);
    assign rd_valid = (count >= RD_STEP);
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_acc = wr_en && wr_ready;
    assign pop_acc  = rd_en && rd_valid;

    always_comb begin
        count_next = count;
        if (push_acc) count_next = count_next + WR_STEP;
        if (pop_acc)  count_next = count_next - RD_STEP;
    end

    // Pointer arithmetic wraps on its own because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            wr_ovf <= 1'b0;
            rd_unf <= 1'b0;
        end else if (clr) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            wr_ovf <= 1'b0;
            rd_unf <= 1'b0;
        end else begin
            if (push_acc) wptr <= wptr + WPTR_INC;
            if (pop_acc)  rptr <= rptr + RPTR_INC;
            count <= count_next;
            if (wr_en && !wr_ready) wr_ovf <= 1'b1;
            if (rd_en && !rd_valid) rd_unf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc && !clr) begin
            for (int i = 0; i < WR_N; i++) begin
                mem[wptr + AW'(i)] <= wr_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RD_N; i++) begin
            rd_data[i*DW +: DW] = mem[rptr + AW'(i)];
        end
    end

endmodule

// File: tb/tb_multi_word_fifo.sv
// Bench for multi_word_fifo: three geometries checked against a queue-of-words model after every edge.
// Instance 0 is the default 4/4, instance 1 a 4-in/2-out narrowing FIFO, instance 2 a 5/5 FIFO whose ops straddle the wrap.
module tb_multi_word_fifo;

    localparam int NI       = 3;
    localparam int DEP      = 16;
    localparam int WN [NI]  = '{4, 4, 5};
    localparam int RN [NI]  = '{4, 2, 5};

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [2:0]  wr_en;
    logic [2:0]  rd_en;
    logic [31:0] wr_a;
    logic [31:0] wr_b;
    logic [39:0] wr_c;
    logic [31:0] rd_a;
    logic [15:0] rd_b;
    logic [39:0] rd_c;
    logic [4:0]  cnt_a;
    logic [4:0]  cnt_b;
    logic [4:0]  cnt_c;
    logic [2:0]  wr_ready;
    logic [2:0]  rd_valid;
    logic [2:0]  full;
    logic [2:0]  empty;
    logic [2:0]  wr_ovf;
    logic [2:0]  rd_unf;

    int checks = 0;
    int errors = 0;

    logic [7:0]  qa [$];
    logic [7:0]  qb [$];
    logic [7:0]  qc [$];
    logic [2:0]  m_ovf;
    logic [2:0]  m_unf;

    always #5 clk = ~clk;

    multi_word_fifo #(.DW(8), .DEPTH(16), .WR_N(4), .RD_N(4)) dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en[0]), .wr_data(wr_a), .wr_ready(wr_ready[0]),
        .rd_en(rd_en[0]), .rd_data(rd_a), .rd_valid(rd_valid[0]),
        .count(cnt_a), .full(full[0]), .empty(empty[0]),
        .wr_ovf(wr_ovf[0]), .rd_unf(rd_unf[0])
    );

    multi_word_fifo #(.DW(8), .DEPTH(16), .WR_N(4), .RD_N(2)) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en[1]), .wr_data(wr_b), .wr_ready(wr_ready[1]),
        .rd_en(rd_en[1]), .rd_data(rd_b), .rd_valid(rd_valid[1]),
        .count(cnt_b), .full(full[1]), .empty(empty[1]),
        .wr_ovf(wr_ovf[1]), .rd_unf(rd_unf[1])
    );

    multi_word_fifo #(.DW(8), .DEPTH(16), .WR_N(5), .RD_N(5)) dut_c (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en[2]), .wr_data(wr_c), .wr_ready(wr_ready[2]),
        .rd_en(rd_en[2]), .rd_data(rd_c), .rd_valid(rd_valid[2]),
        .count(cnt_c), .full(full[2]), .empty(empty[2]),
        .wr_ovf(wr_ovf[2]), .rd_unf(rd_unf[2])
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic logic [7:0] q_at(input int k, input int i);
        case (k)
            0:       return qa[i];
            1:       return qb[i];
            default: return qc[i];
        endcase
    endfunction

    task automatic q_push(input int k, input logic [7:0] w);
        case (k)
            0:       qa.push_back(w);
            1:       qb.push_back(w);
            default: qc.push_back(w);
        endcase
    endtask

    task automatic q_pop(input int k);
        case (k)
            0:       void'(qa.pop_front());
            1:       void'(qb.pop_front());
            default: void'(qc.pop_front());
        endcase
    endtask

    task automatic q_clear(input int k);
        case (k)
            0:       qa.delete();
            1:       qb.delete();
            default: qc.delete();
        endcase
    endtask

    function automatic logic [7:0] wr_word(input int k, input int i);
        case (k)
            0:       return wr_a[i*8 +: 8];
            1:       return wr_b[i*8 +: 8];
            default: return wr_c[i*8 +: 8];
        endcase
    endfunction

    function automatic logic [63:0] obs_rd(input int k);
        case (k)
            0:       return {32'b0, rd_a};
            1:       return {48'b0, rd_b};
            default: return {24'b0, rd_c};
        endcase
    endfunction

    function automatic logic [63:0] obs_cnt(input int k);
        case (k)
            0:       return {59'b0, cnt_a};
            1:       return {59'b0, cnt_b};
            default: return {59'b0, cnt_c};
        endcase
    endfunction

    // Compare every output of instance k with what the word queue implies.
    task automatic checkModel(input int k);
        int n;
        logic [63:0] exp_rd;
        n = q_size(k);
        exp_rd = '0;
        checkOutput($sformatf("count%0d", k), obs_cnt(k), 64'(n));
        checkOutput($sformatf("wr_ready%0d", k), 64'(wr_ready[k]), 64'((DEP - n) >= WN[k]));
        checkOutput($sformatf("rd_valid%0d", k), 64'(rd_valid[k]), 64'(n >= RN[k]));
        checkOutput($sformatf("full%0d", k), 64'(full[k]), 64'(n == DEP));
        checkOutput($sformatf("empty%0d", k), 64'(empty[k]), 64'(n == 0));
        checkOutput($sformatf("wr_ovf%0d", k), 64'(wr_ovf[k]), 64'(m_ovf[k]));
        checkOutput($sformatf("rd_unf%0d", k), 64'(rd_unf[k]), 64'(m_unf[k]));
        if (n >= RN[k]) begin
            for (int i = 0; i < RN[k]; i++) exp_rd[i*8 +: 8] = q_at(k, i);
            checkOutput($sformatf("rd_data%0d", k), obs_rd(k), exp_rd);
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < NI; k++) checkModel(k);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) q_clear(k);
        m_ovf = '0;
        m_unf = '0;
    endtask

    // One clock edge: drive requests, advance the model by the handshake rules, then compare.
    task automatic applyStimulus(input logic [2:0] we, input logic [2:0] re, input logic cl);
        int n;
        bit push_ok;
        bit pop_ok;
        wr_en = we;
        rd_en = re;
        clr   = cl;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (cl) begin
                q_clear(k);
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
            end else begin
                n       = q_size(k);
                push_ok = we[k] && ((DEP - n) >= WN[k]);
                pop_ok  = re[k] && (n >= RN[k]);
                if (we[k] && !push_ok) m_ovf[k] = 1'b1;
                if (re[k] && !pop_ok)  m_unf[k] = 1'b1;
                if (pop_ok)  for (int i = 0; i < RN[k]; i++) q_pop(k);
                if (push_ok) for (int i = 0; i < WN[k]; i++) q_push(k, wr_word(k, i));
            end
        end
        #1;
        checkAll();
        @(negedge clk);
        wr_en = '0;
        rd_en = '0;
        clr   = 1'b0;
    endtask

    initial begin
        logic [31:0] fresh_a;
        rst   = 1'b0;
        clr   = 1'b0;
        wr_en = '0;
        rd_en = '0;
        wr_a  = '0;
        wr_b  = '0;
        wr_c  = '0;
        model_reset();
        #12;
        checkAll();
        checkOutput("rst_empty", 64'(empty), 64'h7);
        checkOutput("rst_wr_ready", 64'(wr_ready), 64'h7);
        @(negedge clk);
        rst = 1'b1;

        wr_a = 32'h03020100;
        applyStimulus(3'b001, 3'b000, 1'b0);
        checkOutput("t1_count", 64'(cnt_a), 64'd4);
        checkOutput("t1_data", 64'(rd_a), 64'h03020100);
        applyStimulus(3'b000, 3'b001, 1'b0);
        checkOutput("t1_empty", 64'(empty[0]), 64'd1);

        for (int j = 0; j < 4; j++) begin
            wr_a = $urandom;
            applyStimulus(3'b001, 3'b000, 1'b0);
        end
        checkOutput("t2_full", 64'(full[0]), 64'd1);
        checkOutput("t2_wr_ready", 64'(wr_ready[0]), 64'd0);
        wr_a = 32'hDEADBEEF;
        applyStimulus(3'b001, 3'b000, 1'b0);
        checkOutput("t2_ovf", 64'(wr_ovf[0]), 64'd1);
        checkOutput("t2_count", 64'(cnt_a), 64'd16);
        for (int j = 0; j < 4; j++) applyStimulus(3'b000, 3'b001, 1'b0);

        applyStimulus(3'b000, 3'b001, 1'b0);
        checkOutput("t3_unf", 64'(rd_unf[0]), 64'd1);
        applyStimulus(3'b000, 3'b000, 1'b1);
        checkOutput("t3_unf_clr", 64'(rd_unf[0]), 64'd0);
        checkOutput("t3_empty", 64'(empty[0]), 64'd1);

        wr_b = 32'hDDCCBBAA;
        applyStimulus(3'b010, 3'b000, 1'b0);
        checkOutput("t4_first", 64'(rd_b), 64'hBBAA);
        applyStimulus(3'b000, 3'b010, 1'b0);
        checkOutput("t4_count2", 64'(cnt_b), 64'd2);
        checkOutput("t4_second", 64'(rd_b), 64'hDDCC);
        applyStimulus(3'b000, 3'b010, 1'b0);
        checkOutput("t4_count0", 64'(cnt_b), 64'd0);

        for (int j = 0; j < 3; j++) begin
            wr_c = {$urandom, $urandom};
            applyStimulus(3'b100, 3'b000, 1'b0);
            applyStimulus(3'b000, 3'b100, 1'b0);
        end
        wr_c = 40'hAA77665544;
        applyStimulus(3'b100, 3'b000, 1'b0);
        checkOutput("t5_wrap", 64'(rd_c), 64'hAA77665544);
        applyStimulus(3'b000, 3'b100, 1'b0);
        checkOutput("t5_empty", 64'(empty[2]), 64'd1);

        applyStimulus(3'b000, 3'b000, 1'b1);
        for (int j = 0; j < 4; j++) begin
            wr_b = $urandom;
            applyStimulus(3'b010, 3'b000, 1'b0);
        end
        applyStimulus(3'b000, 3'b010, 1'b0);
        checkOutput("t6_count14", 64'(cnt_b), 64'd14);
        wr_b = 32'h12345678;
        applyStimulus(3'b010, 3'b010, 1'b0);
        checkOutput("t6_count12", 64'(cnt_b), 64'd12);
        checkOutput("t6_ovf", 64'(wr_ovf[1]), 64'd1);

        applyStimulus(3'b000, 3'b000, 1'b1);
        for (int j = 0; j < 400; j++) begin
            wr_a = $urandom;
            wr_b = $urandom;
            wr_c = {$urandom, $urandom};
            applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset in the middle of a clock period discards everything stored.
        wr_a = $urandom;
        applyStimulus(3'b111, 3'b000, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checkAll();
        @(negedge clk);
        rst = 1'b1;
        fresh_a = $urandom;
        wr_a = fresh_a;
        applyStimulus(3'b001, 3'b000, 1'b0);
        checkOutput("post_rst_data", 64'(rd_a), 64'(fresh_a));
        applyStimulus(3'b001, 3'b001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
